msx_audio_mixer: RTL and testbench

MSX_AUDIO_MIXER -- requirements
Module: msx_audio_mixer

---
 rtl/msx_audio_mixer.sv | 189 ++++++++++++++++++
 tb/tb_msx_audio_mixer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer: multi-channel sample mixer with per-channel gain and pan.
// A ce_sample strobe snapshots all channel inputs. The mixer then adds one
// channel per cycle into separate left and right accumulators. After that it
// applies the master attenuation, clamps each side to OUT_W bits, and
// presents the result with a one-cycle out_valid pulse.
module msx_audio_mixer #(
  parameter int NCH    = 8,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce_sample,
  input  logic [NCH*IN_W-1:0]      ch_in,
  input  logic [NCH*GAIN_W-1:0]    ch_gain,
  input  logic [NCH*2-1:0]         ch_pan,
  input  logic [2:0]               master_vol,
  input  logic                     clip_clr,
  output logic signed [OUT_W-1:0]  out_l,
  output logic signed [OUT_W-1:0]  out_r,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     clip_l,
  output logic                     clip_r,
  output logic                     overrun
);

  localparam int IDX_W  = $clog2(NCH);
  localparam int PROD_W = OUT_W + GAIN_W + 1;
  localparam int ACC_W  = OUT_W + GAIN_W + $clog2(NCH) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_SAT
  } state_t;

  state_t state, state_next;

  logic [NCH*IN_W-1:0]     in_q;
  logic [NCH*GAIN_W-1:0]   gain_q;
  logic [NCH*2-1:0]        pan_q;
  logic [2:0]              vol_q;

  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc_l, acc_r;

  logic signed [IN_W-1:0]   sample;
  logic [GAIN_W-1:0]        gain;
  logic [1:0]               pan;
  logic signed [OUT_W-1:0]  samp_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     to_l, to_r;
  logic                     last_ch;

  logic [3:0]               shamt;
  logic signed [ACC_W-1:0]  scaled_l, scaled_r;
  logic signed [OUT_W-1:0]  sat_l, sat_r;
  logic                     hit_l, hit_r;

  assign busy    = (state != S_IDLE);
  assign last_ch = (idx == IDX_W'(NCH - 1));

  // State register; reset wins over everything, including a coincident ce_sample.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode: one ACCUM cycle per channel, then SCALE, then SAT.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (ce_sample) state_next = S_ACCUM;
      S_ACCUM: if (last_ch)   state_next = S_SCALE;
      S_SCALE: state_next = S_SAT;
      S_SAT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Snapshot of all mix inputs, taken when a mix starts from IDLE.
  always_ff @(posedge clk_sys) begin
    // NOTE: snapshot registers carry no reset; they are always reloaded before being read.
    if (state == S_IDLE && ce_sample) begin
      in_q   <= ch_in;
      gain_q <= ch_gain;
      pan_q  <= ch_pan;
      vol_q  <= master_vol;
    end
  end

  // Current-channel product: the sample is aligned to OUT_W and scaled by the unsigned gain.
  always_comb begin
    sample   = in_q[idx*IN_W +: IN_W];
    gain     = gain_q[idx*GAIN_W +: GAIN_W];
    pan      = pan_q[idx*2 +: 2];
    samp_ext = OUT_W'(sample) <<< (OUT_W - IN_W);
    prod     = PROD_W'(samp_ext) * PROD_W'($signed({1'b0, gain}));
    to_l     = (pan == 2'b00) || (pan == 2'b01);
    to_r     = (pan == 2'b00) || (pan == 2'b10);
  end

  // Master attenuation (unity gain is 8, hence the extra 3) and clamp to OUT_W.
  always_comb begin
    shamt    = 4'd3 + {1'b0, vol_q};
    scaled_l = acc_l >>> shamt;
    scaled_r = acc_r >>> shamt;
    hit_l    = 1'b0;
    hit_r    = 1'b0;
    sat_l    = scaled_l[OUT_W-1:0];
    sat_r    = scaled_r[OUT_W-1:0];
    if (scaled_l > SAT_MAX) begin
      sat_l = SAT_MAX[OUT_W-1:0];
      hit_l = 1'b1;
    end else if (scaled_l < SAT_MIN) begin
      sat_l = SAT_MIN[OUT_W-1:0];
      hit_l = 1'b1;
    end
    if (scaled_r > SAT_MAX) begin
      sat_r = SAT_MAX[OUT_W-1:0];
      hit_r = 1'b1;
    end else if (scaled_r < SAT_MIN) begin
      sat_r = SAT_MIN[OUT_W-1:0];
      hit_r = 1'b1;
    end
  end

  // Accumulate channels, then register the clamped result so it is visible
  // together with out_valid for the whole SAT cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_l     <= '0;
      acc_r     <= '0;
      idx       <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ce_sample) begin
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
          end
        end
        S_ACCUM: begin
          if (to_l) acc_l <= acc_l + ACC_W'(prod);
          if (to_r) acc_r <= acc_r + ACC_W'(prod);
          idx <= idx + 1'b1;
        end
        S_SCALE: begin
          out_l     <= sat_l;
          out_r     <= sat_r;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky status flags. A new set condition takes priority over clip_clr.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clip_l  <= 1'b0;
      clip_r  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state == S_SCALE && hit_l) clip_l <= 1'b1;
      else if (clip_clr)             clip_l <= 1'b0;
      if (state == S_SCALE && hit_r) clip_r <= 1'b1;
      else if (clip_clr)             clip_r <= 1'b0;
      if (ce_sample && busy)         overrun <= 1'b1;
      else if (clip_clr)             overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msx_audio_mixer.sv
// tb_msx_audio_mixer: directed and randomized checks of msx_audio_mixer.
// The bench uses one 16-bit instance and one 8-bit-input instance. Each
// expected mix is computed from integer sums of sample*gain per side. The
// result is then floor-divided by 2^(3+vol) and clamped.
module tb_msx_audio_mixer;

  localparam int NCH = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                reset, ce_sample, ce8, clip_clr;
  logic [NCH*16-1:0]   ch_in;
  logic [NCH*8-1:0]    ch_in8;
  logic [NCH*4-1:0]    ch_gain, ch_gain8;
  logic [NCH*2-1:0]    ch_pan, ch_pan8;
  logic [2:0]          master_vol, master_vol8;
  logic signed [15:0]  out_l, out_r, out_l8, out_r8;
  logic                out_valid, busy, clip_l, clip_r, overrun;
  logic                out_valid8, busy8, clip_l8, clip_r8, overrun8;

  msx_audio_mixer #(.NCH(NCH), .IN_W(16), .OUT_W(16), .GAIN_W(4)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample), .ch_in(ch_in),
    .ch_gain(ch_gain), .ch_pan(ch_pan), .master_vol(master_vol), .clip_clr(clip_clr),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy),
    .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
  );

  msx_audio_mixer #(.NCH(NCH), .IN_W(8), .OUT_W(16), .GAIN_W(4)) u_dut8 (
    .clk_sys(clk_sys), .reset(reset), .ce_sample(ce8), .ch_in(ch_in8),
    .ch_gain(ch_gain8), .ch_pan(ch_pan8), .master_vol(master_vol8), .clip_clr(clip_clr),
    .out_l(out_l8), .out_r(out_r8), .out_valid(out_valid8), .busy(busy8),
    .clip_l(clip_l8), .clip_r(clip_r8), .overrun(overrun8)
  );

  int tests = 0;
  int fails = 0;

  // Stimulus for the next mix, as plain integers.
  int s[NCH];
  int g[NCH];
  int p[NCH];
  int vol;
  longint last_l, last_r;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input int k);
    longint d;
    d = longint'(1) << k;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic void model(input int in_w, output longint el, output longint er,
                                output bit cl, output bit cr);
    longint al, ar, v;
    al = 0;
    ar = 0;
    for (int i = 0; i < NCH; i++) begin
      v = longint'(s[i]) * (longint'(1) << (16 - in_w)) * longint'(g[i]);
      if (p[i] == 0 || p[i] == 1) al += v;
      if (p[i] == 0 || p[i] == 2) ar += v;
    end
    al = floor_div(al, 3 + vol);
    ar = floor_div(ar, 3 + vol);
    cl = (al > 32767) || (al < -32768);
    cr = (ar > 32767) || (ar < -32768);
    el = (al > 32767) ? 32767 : (al < -32768) ? -32768 : al;
    er = (ar > 32767) ? 32767 : (ar < -32768) ? -32768 : ar;
  endfunction

  task automatic apply(input bit use8);
    for (int i = 0; i < NCH; i++) begin
      if (use8) begin
        ch_in8[i*8 +: 8]   = 8'(s[i]);
        ch_gain8[i*4 +: 4] = 4'(g[i]);
        ch_pan8[i*2 +: 2]  = 2'(p[i]);
      end else begin
        ch_in[i*16 +: 16]  = 16'(s[i]);
        ch_gain[i*4 +: 4]  = 4'(g[i]);
        ch_pan[i*2 +: 2]   = 2'(p[i]);
      end
    end
    if (use8) master_vol8 = 3'(vol);
    else      master_vol  = 3'(vol);
  endtask

  // Garbage on the live inputs while a mix runs; the snapshot must shield it.
  task automatic scramble(input bit use8);
    if (use8) begin
      ch_in8 = {$urandom, $urandom};
      ch_gain8 = $urandom;
      ch_pan8 = 16'($urandom);
      master_vol8 = 3'($urandom);
    end else begin
      ch_in = {$urandom, $urandom, $urandom, $urandom};
      ch_gain = $urandom;
      ch_pan = 16'($urandom);
      master_vol = 3'($urandom);
    end
  endtask

  task automatic randomize_stim(input int in_w);
    for (int i = 0; i < NCH; i++) begin
      s[i] = (in_w == 8) ? int'($signed(8'($urandom))) : int'($signed(16'($urandom)));
      g[i] = int'($urandom_range(0, 15));
      p[i] = int'($urandom_range(0, 3));
    end
    vol = int'($urandom_range(0, 7));
  endtask

  task automatic zero_stim();
    for (int i = 0; i < NCH; i++) begin
      s[i] = 0;
      g[i] = 0;
      p[i] = 0;
    end
    vol = 0;
  endtask

  // One full mix: clear flags, strobe, wait (bounded) for out_valid, compare.
  task automatic mix(input bit use8, input string tag);
    longint el, er;
    bit cl, cr;
    int lat;
    model(use8 ? 8 : 16, el, er, cl, cr);
    @(posedge clk_sys); #1;
    apply(use8);
    clip_clr = 1'b1;
    if (use8) ce8 = 1'b1;
    else      ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    clip_clr = 1'b0;
    ce_sample = 1'b0;
    ce8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_sys);
      if ((use8 ? out_valid8 : out_valid) === 1'b1) begin
        lat = n;
        break;
      end
      scramble(use8);
    end
    check({tag, " latency"}, lat, 10);
    last_l = use8 ? longint'(out_l8) : longint'(out_l);
    last_r = use8 ? longint'(out_r8) : longint'(out_r);
    check({tag, " out_l"}, last_l, el);
    check({tag, " out_r"}, last_r, er);
    check({tag, " clip_l"}, use8 ? clip_l8 : clip_l, cl);
    check({tag, " clip_r"}, use8 ? clip_r8 : clip_r, cr);
    @(negedge clk_sys);
    check({tag, " valid pulse width"}, use8 ? out_valid8 : out_valid, 0);
  endtask

  initial begin
    longint el, er;
    bit cl, cr;
    int pulses, first;

    reset = 1'b1;
    ce_sample = 1'b0;
    ce8 = 1'b0;
    clip_clr = 1'b0;
    zero_stim();
    apply(1'b0);
    apply(1'b1);
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check("reset out_l", out_l, 0);
    check("reset out_r", out_r, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset clip_l", clip_l, 0);
    check("reset clip_r", clip_r, 0);
    check("reset overrun", overrun, 0);
    check("reset busy8", busy8, 0);

    // Unity gain on channel 0 only.
    randomize_stim(16);
    for (int i = 0; i < NCH; i++) begin g[i] = 0; p[i] = 0; end
    s[0] = 'h1000; g[0] = 8; vol = 0;
    mix(1'b0, "unity");
    check("unity literal l", last_l, 'h1000);
    check("unity literal r", last_r, 'h1000);

    // Pan split plus one step of master attenuation.
    zero_stim();
    s[0] = 'h2000; g[0] = 8; p[0] = 1;
    s[1] = 'h0800; g[1] = 8; p[1] = 2;
    vol = 1;
    mix(1'b0, "pan_vol");
    check("pan_vol literal l", last_l, 'h1000);
    check("pan_vol literal r", last_r, 'h0400);

    // Positive and negative saturation, then sticky clear.
    zero_stim();
    s[0] = 'h7000; s[1] = 'h7000; g[0] = 15; g[1] = 15;
    mix(1'b0, "sat_pos");
    check("sat_pos literal l", last_l, 32767);
    for (int i = 0; i < NCH; i++) begin s[i] = -32768; g[i] = 15; p[i] = 0; end
    mix(1'b0, "sat_neg");
    check("sat_neg literal r", last_r, -32768);
    @(posedge clk_sys); #1 clip_clr = 1'b1;
    @(posedge clk_sys); #1 clip_clr = 1'b0;
    @(negedge clk_sys);
    check("clip_clr clip_l", clip_l, 0);
    check("clip_clr clip_r", clip_r, 0);

    // Second strobe during ACCUM is dropped and flagged.
    randomize_stim(16);
    model(16, el, er, cl, cr);
    @(posedge clk_sys); #1;
    apply(1'b0);
    ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    scramble(1'b0);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    pulses = 0;
    first = -1;
    for (int n = 4; n <= 25; n++) begin
      @(negedge clk_sys);
      if (out_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n;
          last_l = out_l;
          last_r = out_r;
        end
      end
    end
    check("overrun pulses", pulses, 1);
    check("overrun latency", first, 10);
    check("overrun flag", overrun, 1);
    check("overrun out_l", last_l, el);
    check("overrun out_r", last_r, er);

    // Strobe coincident with out_valid is an overrun and starts nothing.
    @(posedge clk_sys); #1 clip_clr = 1'b1;
    @(posedge clk_sys); #1 clip_clr = 1'b0;
    randomize_stim(16);
    @(posedge clk_sys); #1;
    apply(1'b0);
    ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_sys);
      if (out_valid === 1'b1) begin
        first = n;
        break;
      end
    end
    check("sat overrun latency", first, 10);
    ce_sample = 1'b1;
    @(posedge clk_sys); #1 ce_sample = 1'b0;
    @(negedge clk_sys);
    check("sat overrun busy", busy, 0);
    check("sat overrun flag", overrun, 1);

    // Reset in cycle 4 of a mix aborts it.
    randomize_stim(16);
    @(posedge clk_sys); #1;
    apply(1'b0);
    ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    ce_sample = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_sys);
      if (out_valid === 1'b1) pulses++;
    end
    check("abort pulses", pulses, 0);
    check("abort busy", busy, 0);
    check("abort out_l", out_l, 0);
    check("abort out_r", out_r, 0);
    check("abort overrun", overrun, 0);

    // Strobe coincident with reset is ignored.
    @(posedge clk_sys); #1;
    reset = 1'b1;
    ce_sample = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    ce_sample = 1'b0;
    @(negedge clk_sys);
    check("reset+ce busy", busy, 0);

    // Random mixes on the 16-bit instance.
    for (int t = 0; t < 10; t++) begin
      randomize_stim(16);
      mix(1'b0, $sformatf("rand16_%0d", t));
    end

    // 8-bit input instance.
    zero_stim();
    s[0] = 'h40; g[0] = 8;
    mix(1'b1, "in8_unity");
    check("in8 literal l", last_l, 'h4000);
    randomize_stim(8);
    for (int i = 0; i < NCH; i++) p[i] = 3;
    mix(1'b1, "in8_mute");
    check("in8 mute literal", last_l, 0);
    for (int t = 0; t < 4; t++) begin
      randomize_stim(8);
      mix(1'b1, $sformatf("rand8_%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
